bit_debouncer: RTL and testbench
================================

// Module: bit_debouncer
// PURPOSE
//  Conditions one raw asynchronous control bit (button, switch or external strobe) before it
//  reaches the single-bit register stage. It synchronises the input, filters glitches shorter
//  than STABLE_CYCLES enabled samples, and produces a clean level plus 1-cycle rise/fall pulses.
//  Its q output feeds the d input of the downstream flip-flop stage directly.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser flop count; legal range >= 2
//  STABLE_CYCLES  4  consecutive enabled samples that differ from q before q updates; >= 1
//  CNT_W          8  stability counter width; 2**CNT_W-1 >= STABLE_CYCLES-1
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = in reset)
//  d          in   1      raw asynchronous input
//  en         in   1      sample-enable tick; tie to 1 to sample every cycle
//  q          out  1      debounced level
//  rise       out  1      1-cycle pulse when q goes 0->1
//  fall       out  1      1-cycle pulse when q goes 1->0
//  glitch_cnt out  8      only with BIT_DEBOUNCER_GLITCH_CNT_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset=0, async, takes effect without a clock edge):
//    sync chain=0, s=0, cnt=0, state=STABLE, q=0, rise=0, fall=0, glitch_cnt=0.
//    Reset dominates every other event.
//  - Sync chain: shifts on every clk regardless of en. s is the last stage.
//  - FSM states:
//    - STABLE (cnt==0).
//      - en && s!=q: if STABLE_CYCLES==1, q<=s immediately; else cnt<=1 and go to CHANGING.
//    - CHANGING.
//      - en && s!=q && cnt==STABLE_CYCLES-1: q<=s, cnt<=0, go to STABLE.
//      - en && s!=q: cnt<=cnt+1.
//      - s==q (any en): cnt<=0, go to STABLE; this is an aborted transition (glitch).
//      - en==0 && s!=q: hold cnt and state.
//  - Latency with en=1: d stable before edge 1 -> q changes on edge SYNC_STAGES+STABLE_CYCLES
//    (defaults: edge 6).
//  - rise/fall: registered, asserted on the same edge q changes, cleared on the next edge.
//    Never both 1 together; never asserted when q does not change.
//  - cnt never exceeds STABLE_CYCLES-1; no wrap.
//  - Any d pulse shorter than STABLE_CYCLES enabled samples (after sync) leaves q unchanged.
//  - Reset mid-transition discards the pending count; q returns to 0.
//    After release, a held d=1 needs the full latency again.
// CONFIGURATION
//  BIT_DEBOUNCER_GLITCH_CNT_EN defined:
//    - glitch_cnt port exists: an 8-bit saturating counter.
//    - Increments by 1 on each aborted transition (CHANGING -> STABLE with no q update).
//    - Holds at 255. Cleared only by reset.
//  Not defined: glitch_cnt port and its logic are absent; all other behaviour is identical.
// TESTING
//  1 reset=0, d=1 for 3 clk -> q=0, rise=0, fall=0 throughout, with no clock edge needed
//    to clear them.
//  2 release reset, en=1, d=1 held -> q=1 on edge 6; rise=1 for exactly 1 cycle; fall stays 0.
//  3 q=1, d=0 for 2 clk then d=1 -> q stays 1, no pulses, glitch_cnt=1 (macro on).
//  4 q=1, d=0 held -> q=0 on edge 6; fall pulses 1 cycle; a further 20 cycles show no pulses.
//  5 en=1 every 4th clk, d=1 held -> q rises on the 4th enabled tick after s goes high;
//    no change between ticks.
//  6 mid-transition (cnt=2) pull reset=0 between edges -> q, cnt, rise, fall =0 immediately;
//    300 glitches -> glitch_cnt=255 (saturated).

Source files
------------

// File: rtl/bit_debouncer.sv
// Synchronising glitch filter for one raw control bit: clean level plus 1-cycle rise/fall pulses.
// Optional aborted-transition counter on glitch_cnt when BIT_DEBOUNCER_GLITCH_CNT_EN is defined.
module bit_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic       en,
  output logic       q,
  output logic       rise,
  output logic       fall
`ifdef BIT_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam logic [0:0]       StStable   = 1'b0;
  localparam logic [0:0]       StChanging = 1'b1;
  localparam logic [CNT_W-1:0] CntLast    = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   abort;

  // The synchroniser runs every cycle; en only gates the stability filter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    abort   = 1'b0;
    unique case (state_q)
      StStable: begin
        if (en && (s != level_q)) begin
          if (STABLE_CYCLES == 1) begin
            level_d = s;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = StChanging;
          end
        end
      end
      StChanging: begin
        // Input fell back to the current level before the count completed.
        if (s == level_q) begin
          cnt_d   = '0;
          state_d = StStable;
          abort   = 1'b1;
        end else if (en) begin
          if (cnt_q == CntLast) begin
            level_d = s;
            cnt_d   = '0;
            state_d = StStable;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  assign rise_d = level_d & ~level_q;
  assign fall_d = ~level_d & level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StStable;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = level_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef BIT_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_q <= 8'd0;
    end else if (abort && (glitch_q != 8'hff)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_bit_debouncer.sv
// Self-checking bench for bit_debouncer: vector table plus hand sequences, checked via a scoreboard.
module tb_bit_debouncer;

  typedef struct {
    int          id;
    logic        d;
    logic        en;
    logic        q;
    logic        rise;
    logic        fall;
    logic        gl_chk;
    int unsigned gl;
  } vec_t;

  logic clk;
  logic reset;
  logic d;
  logic en;
  logic q;
  logic rise;
  logic fall;
`ifdef BIT_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int   n_tests;
  int   n_fail;
  int   n_id;
  vec_t tbl[$];
  vec_t sb[$];

  bit_debouncer dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .en   (en),
    .q    (q),
    .rise (rise),
    .fall (fall)
`ifdef BIT_DEBOUNCER_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: every posedge retires the oldest outstanding expectation.
  always @(posedge clk) begin
    vec_t v;
    #1;
    if (sb.size() != 0) begin
      v = sb.pop_front();
      n_tests++;
      if ({q, rise, fall} !== {v.q, v.rise, v.fall}) begin
        n_fail++;
        $display("FAIL vec%0d q/rise/fall got %b%b%b want %b%b%b", v.id, q, rise, fall,
                 v.q, v.rise, v.fall);
      end
`ifdef BIT_DEBOUNCER_GLITCH_CNT_EN
      if (v.gl_chk) begin
        n_tests++;
        if (glitch_cnt !== 8'(v.gl)) begin
          n_fail++;
          $display("FAIL vec%0d glitch_cnt got %0d want %0d", v.id, glitch_cnt, v.gl);
        end
      end
`endif
    end
  end

  function automatic vec_t mk(logic vd, logic ven, logic vq, logic vr, logic vf, logic gc,
                              int unsigned g);
    vec_t v;
    v.id = 0; v.d = vd; v.en = ven; v.q = vq; v.rise = vr; v.fall = vf; v.gl_chk = gc; v.gl = g;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    v.id = n_id++;
    d    = v.d;
    en   = v.en;
    sb.push_back(v);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; d = 1'b0; en = 1'b0;
    n_tests = 0; n_fail = 0; n_id = 0;

    // Rise after release: q on edge 6.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 1, i >= 5, i == 5, 0, 1, 0));
    // Two-sample low glitch from q=1: aborted on the 5th edge.
    for (int i = 0; i < 7; i++) tbl.push_back(mk(i >= 2, 1, 1, 0, 0, 1, (i >= 4) ? 1 : 0));
    // Fall with d=0 held, then 20 quiet cycles.
    for (int i = 0; i < 26; i++) tbl.push_back(mk(0, 1, i < 5, 0, i == 5, 1, 1));
    // en every 4th clock: rise on the 4th enabled tick.
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk(1, (i % 4) == 3, i >= 15, i == 15, 0, 1, 1));

    #1 reset = 1'b0;
    #1;
    chk("async_reset_q", q, 1'b0);
    chk("async_reset_rise", rise, 1'b0);
    chk("async_reset_fall", fall, 1'b0);
`ifdef BIT_DEBOUNCER_GLITCH_CNT_EN
    chk("async_reset_gl_zero", glitch_cnt == 8'd0, 1'b1);
`endif

    @(negedge clk);
    for (int i = 0; i < 3; i++) run_vec(mk(1, 1, 0, 0, 0, 1, 0));
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Mid-fall (count at 2), reset between edges.
    for (int i = 0; i < 4; i++) run_vec(mk(0, 1, 1, 0, 0, 1, 1));
    reset = 1'b0;
    #1;
    chk("midreset_q", q, 1'b0);
    chk("midreset_rise", rise, 1'b0);
    chk("midreset_fall", fall, 1'b0);
    for (int i = 0; i < 2; i++) run_vec(mk(1, 1, 0, 0, 0, 1, 0));
    reset = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(mk(1, 1, i >= 5, i == 5, 0, 1, 0));

    // 300 glitches from q=1; counter saturates at 255.
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 5; j++)
        run_vec(mk(j >= 2, 1, 1, 0, 0, j == 4, (k + 1 > 255) ? 255 : k + 1));
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
